dmem_ctrl: RTL and testbench

Sequencing and arbitration controller in front of the single-port word-addressed data memory (1024 x 32 bit, synchronous write, asynchronous read). Shares the memory between the pipeline MEM stage (cpu port) and a loader/debug port (dbg port). Performs sub-word loads with sign/zero extension. Performs byte/halfword stores as read-modify-write, because the memory has no byte enables.

---
 rtl/dmem_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: arbitrated cpu/dbg front end for a 1024x32 single-port data memory with
// extended sub-word loads and read-modify-write sub-word stores. Optional: DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        dbg_req_valid,
  output logic        dbg_req_ready,
  input  logic        dbg_we,
  input  logic [1:0]  dbg_size,
  input  logic        dbg_unsigned,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_resp_valid,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Handshake: a request transfers in a cycle where *_req_valid and *_req_ready are both high;
  // ready is offered only in IDLE to the arbitration winner, and *_resp_valid pulses once on completion.
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state, state_nx;
  logic        owner_q;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [2:0]  starve_cnt;

  logic        grant_cpu, grant_dbg, accept, trap;
  logic        in_we, in_uns;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val, merged;

  // cpu has priority unless dbg has been passed over STARVE_LIMIT times in a row
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (state == IDLE && !rst) begin
      if (dbg_req_valid && (!cpu_req_valid || starve_cnt == 3'(STARVE_LIMIT)))
        grant_dbg = 1'b1;
      else if (cpu_req_valid)
        grant_cpu = 1'b1;
    end
  end

  assign accept = grant_cpu | grant_dbg;

  always_comb begin
    in_we    = grant_dbg ? dbg_we       : cpu_we;
    in_size  = grant_dbg ? dbg_size     : cpu_size;
    in_uns   = grant_dbg ? dbg_unsigned : cpu_unsigned;
    in_addr  = grant_dbg ? dbg_addr     : cpu_addr;
    in_wdata = grant_dbg ? dbg_wdata    : cpu_wdata;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    case (in_size)
      2'b00:   trap = 1'b0;
      2'b01:   trap = in_addr[0];
      default: trap = (in_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign trap = 1'b0;
`endif

  // Lane extraction for loads and lane replacement for the RMW merge
  always_comb begin
    byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_lane = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    load_val  = mem_rdata;
    merged    = mem_rdata;
    case (size_q)
      2'b00: begin
        load_val = {{24{~uns_q & byte_lane[7]}}, byte_lane};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = {{16{~uns_q & half_lane[15]}}, half_lane};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = trap ? RESP : ACCESS;
      ACCESS:  state_nx = (we_q && !size_q[1]) ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nx;
      if (!dbg_req_valid || grant_dbg)
        starve_cnt <= '0;
      else if (grant_cpu)
        starve_cnt <= starve_cnt + 3'd1;
      if (accept) begin
        owner_q <= grant_dbg;
        we_q    <= in_we;
        size_q  <= in_size;
        uns_q   <= in_uns;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        err_q   <= trap;
        data_q  <= '0;
      end
      // data_q carries the load result, or the merged word between ACCESS and WRITE
      if (state == ACCESS)
        data_q <= !we_q ? load_val : (size_q[1] ? '0 : merged);
    end
  end

  always_comb begin
    cpu_req_ready  = 1'b0;
    dbg_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    dbg_resp_valid = 1'b0;
    cpu_rdata      = '0;
    dbg_rdata      = '0;
    cpu_err        = 1'b0;
    dbg_err        = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    if (!rst) begin
      cpu_req_ready = grant_cpu;
      dbg_req_ready = grant_dbg;
      if (state != IDLE) mem_addr = {addr_q[31:2], 2'b00};
      case (state)
        ACCESS: begin
          if (we_q && size_q[1]) begin
            mem_write = 1'b1;
            mem_wdata = wdata_q;
          end else begin
            mem_read = 1'b1;
          end
        end
        WRITE: begin
          mem_write = 1'b1;
          mem_wdata = data_q;
        end
        RESP: begin
          cpu_resp_valid = !owner_q;
          dbg_resp_valid = owner_q;
          if (!owner_q) begin
            cpu_rdata = we_q ? '0 : data_q;
            cpu_err   = err_q;
          end else begin
            dbg_rdata = we_q ? '0 : data_q;
            dbg_err   = err_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: dmem_ctrl with a 1024x32 memory, a behavioural reference model and directed cases.
`timescale 1ns/1ps
module tb_dmem_ctrl;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_valid, cpu_req_ready, cpu_we, cpu_unsigned;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_resp_valid, cpu_err;
  logic        dbg_req_valid, dbg_req_ready, dbg_we, dbg_unsigned;
  logic [1:0]  dbg_size;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_resp_valid, dbg_err;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_ctrl #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_we(cpu_we),
    .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_we(dbg_we),
    .dbg_size(dbg_size), .dbg_unsigned(dbg_unsigned), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_resp_valid(dbg_resp_valid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // the data memory: synchronous write, asynchronous read, aliased every 4 KB
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event at cycle %0d", name, cyc);
  endtask

  // reference model: one outstanding transaction, described by what it must do and when
  typedef struct {
    int          acc;
    int          lat;
    bit          owner;
    logic [31:0] rdata;
    bit          err;
    logic [31:0] maddr;
    bit          wr1;
    logic [31:0] w1data;
    logic [31:0] merged;
  } exp_t;

  exp_t exp_q[$];
  int   m_starve = 0;

  function automatic void model_op(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   output exp_t e);
    int nbytes, off, idx;
    logic [31:0] mask, word, lane;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off    = (int'(addr[1:0]) / nbytes) * nbytes * 8;
    mask   = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (nbytes * 8)) - 32'h1);
    idx    = int'(addr[11:2]);
    word   = ref_mem[idx];
    e.acc = 0; e.owner = 0; e.err = 0; e.rdata = '0;
    e.maddr = addr & 32'hFFFF_FFFC;
    e.wr1 = 0; e.w1data = '0; e.merged = '0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((int'(addr[1:0]) % nbytes) != 0) begin
      e.err = 1;
      e.lat = 1;
      return;
    end
`endif
    if (!we) begin
      lane = (word >> off) & mask;
      if (!uns && nbytes < 4 && lane[nbytes * 8 - 1]) lane = lane | ~mask;
      e.rdata = lane;
      e.lat   = 2;
    end else begin
      e.merged = (word & ~(mask << off)) | ((wdata & mask) << off);
      e.wr1    = (nbytes == 4);
      e.w1data = wdata;
      e.lat    = (nbytes == 4) ? 2 : 3;
      ref_mem[idx] = e.merged;
    end
  endfunction

  // scoreboard: every cycle, DUT outputs against the model's view of that cycle
  always @(negedge clk) begin : cmp
    bit   idle, gc, gd;
    exp_t e;
    int   k;
    if (chk_on) begin
      idle = (exp_q.size() == 0);
      gc = 0;
      gd = 0;
      if (idle) begin
        if (dbg_req_valid && (!cpu_req_valid || m_starve == STARVE_LIMIT)) gd = 1;
        else if (cpu_req_valid) gc = 1;
      end
      chk("cpu_req_ready", cpu_req_ready, gc);
      chk("dbg_req_ready", dbg_req_ready, gd);
      if (idle) begin
        chk("idle resp", {cpu_resp_valid, dbg_resp_valid}, 0);
        chk("idle strobes", {mem_read, mem_write}, 0);
      end else begin
        e = exp_q[0];
        k = cyc - e.acc;
        chk("mem_addr", mem_addr, e.maddr);
        if (k == e.lat) begin
          chk("resp owner", {dbg_resp_valid, cpu_resp_valid}, e.owner ? 2'b10 : 2'b01);
          chk("resp rdata", e.owner ? dbg_rdata : cpu_rdata, e.rdata);
          chk("resp err", e.owner ? dbg_err : cpu_err, e.err);
          chk("resp strobes", {mem_read, mem_write}, 0);
          void'(exp_q.pop_front());
        end else begin
          chk("early resp", {cpu_resp_valid, dbg_resp_valid}, 0);
          if (k == 1) begin
            if (e.wr1) begin
              chk("word write strobes", {mem_read, mem_write}, 2'b01);
              chk("word write data", mem_wdata, e.w1data);
            end else begin
              chk("read strobes", {mem_read, mem_write}, 2'b10);
            end
          end else begin
            chk("rmw write strobes", {mem_read, mem_write}, 2'b01);
            chk("rmw write data", mem_wdata, e.merged);
          end
        end
      end
      if (gc) begin
        model_op(cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata, e);
        e.acc = cyc; e.owner = 0;
        exp_q.push_back(e);
      end else if (gd) begin
        model_op(dbg_we, dbg_size, dbg_unsigned, dbg_addr, dbg_wdata, e);
        e.acc = cyc; e.owner = 1;
        exp_q.push_back(e);
      end
      if (!dbg_req_valid || gd) m_starve = 0;
      else if (gc) m_starve++;
    end
  end

  // driver tasks
  task automatic set_port(input bit p, input logic v, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (!p) begin
      cpu_req_valid = v; cpu_we = we; cpu_size = size;
      cpu_unsigned = uns; cpu_addr = addr; cpu_wdata = wdata;
    end else begin
      dbg_req_valid = v; dbg_we = we; dbg_size = size;
      dbg_unsigned = uns; dbg_addr = addr; dbg_wdata = wdata;
    end
  endtask

  task automatic rand_port(input bit p, input logic v);
    logic [31:0] a;
    a = 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
    set_port(p, v, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom);
  endtask

  task automatic do_op(input bit p, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er, output int lat);
    int t0;
    bit got;
    rd = '0; er = 1'b0; lat = -1; t0 = 0; got = 0;
    set_port(p, 1'b1, we, size, uns, addr, wdata);
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (p ? dbg_req_ready : cpu_req_ready) begin got = 1; t0 = cyc; end
    end
    @(posedge clk); #1;
    rand_port(p, 1'b0);
    if (!got) begin fail_now("accept wait"); return; end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (p ? dbg_resp_valid : cpu_resp_valid) begin
        got = 1;
        rd  = p ? dbg_rdata : cpu_rdata;
        er  = p ? dbg_err : cpu_err;
        lat = cyc - t0;
      end
    end
    if (!got) fail_now("response wait");
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          gq[$];

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    set_port(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0);
    // hold a sub-word store request through reset: nothing may be granted
    set_port(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h40, 32'h55);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", {cpu_req_ready, dbg_req_ready}, 0);
    chk("reset resp", {cpu_resp_valid, dbg_resp_valid, cpu_err, dbg_err}, 0);
    chk("reset rdata", cpu_rdata | dbg_rdata, 0);
    chk("reset strobes", {mem_read, mem_write}, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);

    // reset during the WRITE phase of sb 0x55 @ 0x040
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rmw accept", cpu_req_ready, 1);
    @(posedge clk); #1 cpu_req_valid = 1'b0;
    @(negedge clk);
    chk("rmw read phase", {mem_read, mem_write}, 2'b10);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("write under reset", {mem_read, mem_write}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post reset strobes", {mem_read, mem_write, cpu_resp_valid, dbg_resp_valid}, 0);
    chk("post reset mem_addr", mem_addr, 0);
    chk("post reset ready", {cpu_req_ready, dbg_req_ready}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no resp after reset", {cpu_resp_valid, dbg_resp_valid}, 0);
    end
    chk("dropped rmw word", mem[16], 32'h0);
    @(posedge clk); #1 chk_on = 1'b1;

    // directed cases
    do_op(0, 1, 2'd2, 0, 32'h010, 32'hDEAD_BEEF, rd, er, lat);
    chk("sw latency", 32'(lat), 2);
    chk("sw rdata", rd, 0);
    do_op(0, 0, 2'd2, 0, 32'h010, 32'h0, rd, er, lat);
    chk("lw data", rd, 32'hDEAD_BEEF);
    chk("lw latency", 32'(lat), 2);
    do_op(1, 1, 2'd2, 0, 32'h020, 32'h1122_3344, rd, er, lat);
    do_op(0, 1, 2'd0, 0, 32'h021, 32'h0000_00AA, rd, er, lat);
    chk("sb latency", 32'(lat), 3);
    chk("sb memory word", mem[8], 32'h1122_AA44);
    do_op(0, 0, 2'd0, 0, 32'h021, 32'h0, rd, er, lat);
    chk("lb data", rd, 32'hFFFF_FFAA);
    do_op(0, 0, 2'd0, 1, 32'h021, 32'h0, rd, er, lat);
    chk("lbu data", rd, 32'h0000_00AA);
    do_op(0, 1, 2'd2, 0, 32'h030, 32'h8001_7FFF, rd, er, lat);
    do_op(0, 0, 2'd1, 0, 32'h032, 32'h0, rd, er, lat);
    chk("lh data", rd, 32'hFFFF_8001);
    do_op(0, 0, 2'd1, 1, 32'h030, 32'h0, rd, er, lat);
    chk("lhu data", rd, 32'h0000_7FFF);
    do_op(0, 1, 2'd2, 0, 32'h040, 32'hCAFE_F00D, rd, er, lat);
    do_op(0, 0, 2'd2, 0, 32'h042, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("misaligned lw err", er, 1);
    chk("misaligned lw rdata", rd, 0);
    chk("misaligned lw latency", 32'(lat), 1);
`else
    chk("misaligned lw err", er, 0);
    chk("misaligned lw rdata", rd, 32'hCAFE_F00D);
    chk("misaligned lw latency", 32'(lat), 2);
`endif
    do_op(0, 0, 2'd2, 0, 32'h1010, 32'h0, rd, er, lat);
    chk("aliased lw", rd, 32'hDEAD_BEEF);
    do_op(1, 0, 2'd0, 1, 32'h043, 32'h0, rd, er, lat);
    chk("dbg lbu", rd, 32'h0000_00CA);

    // starvation: both ports continuously valid
    @(posedge clk); #1;
    rand_port(0, 1'b1);
    rand_port(1, 1'b1);
    for (int i = 0; i < 200 && gq.size() < 10; i++) begin
      int g;
      @(negedge clk);
      g = cpu_req_ready ? 1 : (dbg_req_ready ? 2 : 0);
      if (g != 0) gq.push_back(g);
      @(posedge clk); #1;
      if (g == 1) rand_port(0, 1'b1);
      if (g == 2) rand_port(1, 1'b1);
    end
    if (gq.size() < 10) fail_now("starvation grants");
    else for (int i = 0; i < 10; i++) chk("grant order", 32'(gq[i]), (i % 5 == 4) ? 2 : 1);

    // random traffic on both ports
    for (int n = 0; n < 3000; n++) begin
      bit ac, ad;
      @(negedge clk);
      ac = cpu_req_valid && cpu_req_ready;
      ad = dbg_req_valid && dbg_req_ready;
      @(posedge clk); #1;
      if (!cpu_req_valid || ac) rand_port(0, 1'($urandom_range(0, 2) != 0));
      if (!dbg_req_valid || ad) rand_port(1, 1'($urandom_range(0, 2) != 0));
    end
    cpu_req_valid = 1'b0;
    dbg_req_valid = 1'b0;
    begin
      bit drained;
      drained = 0;
      for (int i = 0; i < 20 && !drained; i++) begin
        @(negedge clk);
        drained = (exp_q.size() == 0);
      end
      if (!drained) fail_now("drain");
    end
    @(negedge clk);
    begin
      int nmis;
      nmis = 0;
      for (int i = 0; i < 1024; i++) begin
        if (mem[i] !== ref_mem[i]) begin
          if (nmis == 0) $display("FAIL memory word %0d: got %h expected %h", i, mem[i], ref_mem[i]);
          nmis++;
        end
      end
      chk("final memory mismatches", 32'(nmis), 0);
    end
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
